code_memory_high_bank: RTL and testbench

Writable 16-word register bank that holds the high half of the i281 code memory. It sits directly downstream of the high user-code constant block and consumes its 16 preset instruction words b0I..b15I. After reset, or on request, it copies those words into its own storage one word per cycle. Once loaded, it serves single-word instruction reads to the fetch logic and accepts single-word overwrites from the programming path.

---
 rtl/code_memory_high_bank_if.sv | 27 ++
 rtl/code_memory_high_bank.sv | 122 ++++++++++++
 tb/tb_code_memory_high_bank.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_memory_high_bank_if.sv
// Read/write port bundle between the fetch/programming logic (master)
// and the high code-memory bank (slave).
interface code_memory_high_bank_if;
  // Handshake: a request (rd_en or wr_en) is taken on any rising edge while the
  // bank is READY and reload is low. There is no back-pressure: an accepted read
  // answers with a one-cycle rd_valid pulse carrying rd_data one edge later, and
  // an accepted write answers with a one-cycle wr_ack pulse. Requests made
  // during LOAD, or on the reload edge, are dropped without a response.
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, wr_ack
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, wr_ack
  );
endinterface

// File: rtl/code_memory_high_bank.sv
// High half of the i281 code memory: 16 x 16-bit bank that copies its presets
// after reset or reload, then serves reads and run-time overwrites.
module code_memory_high_bank (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [15:0] b0I,
  input  logic [15:0] b1I,
  input  logic [15:0] b2I,
  input  logic [15:0] b3I,
  input  logic [15:0] b4I,
  input  logic [15:0] b5I,
  input  logic [15:0] b6I,
  input  logic [15:0] b7I,
  input  logic [15:0] b8I,
  input  logic [15:0] b9I,
  input  logic [15:0] b10I,
  input  logic [15:0] b11I,
  input  logic [15:0] b12I,
  input  logic [15:0] b13I,
  input  logic [15:0] b14I,
  input  logic [15:0] b15I,
  input  logic        reload,
  output logic        ready,
  output logic [3:0]  load_idx,
  output logic        fsm_state,
  code_memory_high_bank_if.slave bus
);

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] mem [16];
  logic [15:0] presets [16];
  logic        load_we, user_we, rd_acc;

  assign presets[0]  = b0I;
  assign presets[1]  = b1I;
  assign presets[2]  = b2I;
  assign presets[3]  = b3I;
  assign presets[4]  = b4I;
  assign presets[5]  = b5I;
  assign presets[6]  = b6I;
  assign presets[7]  = b7I;
  assign presets[8]  = b8I;
  assign presets[9]  = b9I;
  assign presets[10] = b10I;
  assign presets[11] = b11I;
  assign presets[12] = b12I;
  assign presets[13] = b13I;
  assign presets[14] = b14I;
  assign presets[15] = b15I;

  // reload outranks everything: it suppresses the copy step, writes and reads.
  assign load_we = (state_q == LOAD)  && !reload;
  assign user_we = (state_q == READY) && !reload && bus.wr_en;
  assign rd_acc  = (state_q == READY) && !reload && bus.rd_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      LOAD: begin
        if (reload) begin
          idx_d = 4'd0;
        end else if (idx_q == 4'd15) begin
          state_d = READY;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      READY: begin
        if (reload) begin
          state_d = LOAD;
          idx_d   = 4'd0;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= LOAD;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The read samples mem before this edge's write lands: read-before-write.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
      bus.rd_data  <= 16'h0000;
      bus.rd_valid <= 1'b0;
      bus.wr_ack   <= 1'b0;
    end else begin
      if (load_we) begin
        mem[idx_q] <= presets[idx_q];
      end else if (user_we) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
      if (rd_acc) bus.rd_data <= mem[bus.rd_addr];
      bus.rd_valid <= rd_acc;
      bus.wr_ack   <= user_we;
    end
  end

  assign ready     = (state_q == READY);
  assign load_idx  = idx_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_code_memory_high_bank.sv
// Randomized self-checking bench for code_memory_high_bank against a
// word-array model of the bank contents and the load/ready timeline.
module tb_code_memory_high_bank;

  logic        Clock;
  logic        Reset_n;
  logic [15:0] b [16];
  logic        reload;
  logic        ready;
  logic [3:0]  load_idx;
  logic        fsm_state;

  code_memory_high_bank_if bus ();

  code_memory_high_bank dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .b0I(b[0]),   .b1I(b[1]),   .b2I(b[2]),   .b3I(b[3]),
    .b4I(b[4]),   .b5I(b[5]),   .b6I(b[6]),   .b7I(b[7]),
    .b8I(b[8]),   .b9I(b[9]),   .b10I(b[10]), .b11I(b[11]),
    .b12I(b[12]), .b13I(b[13]), .b14I(b[14]), .b15I(b[15]),
    .reload(reload), .ready(ready), .load_idx(load_idx),
    .fsm_state(fsm_state), .bus(bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_mem [16];
  logic [15:0] last_rd;
  logic [15:0] exp_q [$];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_en = 1'b0; bus.rd_addr = 4'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 16'h0000;
    reload = 1'b0;
  endtask

  // Model of a full copy: all 16 words take the current presets.
  task automatic model_load();
    for (int i = 0; i < 16; i++) model_mem[i] = b[i];
  endtask

  // Counts 16 load edges after the load started; ready only after the 16th.
  task automatic wait_load(input string tag);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ready !== 1'b0 || load_idx !== 4'(k)) begin
        errors++;
        $display("FAIL %s_loading k=%0d ready=%b load_idx=%0d want ready=0 load_idx=%0d", tag, k, ready, load_idx, k);
      end
      step();
    end
    checks++;
    if (ready !== 1'b1 || load_idx !== 4'd0) begin
      errors++;
      $display("FAIL %s_ready ready=%b load_idx=%0d want ready=1 load_idx=0", tag, ready, load_idx);
    end
    model_load();
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = 4'(a);
      step();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== model_mem[a]) begin
        errors++;
        $display("FAIL %s_read addr=%0d got valid=%b data=%h want valid=1 data=%h", tag, a, bus.rd_valid, bus.rd_data, model_mem[a]);
      end
      last_rd = model_mem[a];
    end
    bus.rd_en = 1'b0;
    step();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== last_rd) begin
      errors++;
      $display("FAIL %s_read_idle got valid=%b data=%h want valid=0 data=%h", tag, bus.rd_valid, bus.rd_data, last_rd);
    end
  endtask

  task automatic read_one(input string tag, input logic [3:0] a, input logic [15:0] want);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    step();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== want) begin
      errors++;
      $display("FAIL %s addr=%0d got valid=%b data=%h want valid=1 data=%h", tag, a, bus.rd_valid, bus.rd_data, want);
    end
    last_rd = want;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < 16; i++) b[i] = 16'h1000 + 16'(i);
    Reset_n = 1'b0;
    #12;
    checks++;
    if (bus.rd_data !== 16'h0 || bus.rd_valid !== 1'b0 || bus.wr_ack !== 1'b0 || ready !== 1'b0 || load_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs rd_data=%h rd_valid=%b wr_ack=%b ready=%b load_idx=%0d want all 0", bus.rd_data, bus.rd_valid, bus.wr_ack, ready, load_idx);
    end
    step();
    Reset_n = 1'b1;
    wait_load("reset_load");
    read_all("reset");
  endtask

  task automatic test_write();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
    step();
    bus.wr_en = 1'b0;
    model_mem[5] = 16'hBEEF;
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++; $display("FAIL write_ack got %b want 1", bus.wr_ack);
    end
    step();
    checks++;
    if (bus.wr_ack !== 1'b0) begin
      errors++; $display("FAIL write_ack_pulse got %b want 0", bus.wr_ack);
    end
    read_one("write_rd5", 4'd5, 16'hBEEF);
    read_one("write_rd4", 4'd4, 16'h1004);
  endtask

  task automatic test_collision();
    bus.rd_en = 1'b1; bus.rd_addr = 4'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h0A0A;
    step();
    idle_inputs();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h1003 || bus.wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL collision got valid=%b data=%h ack=%b want valid=1 data=1003 ack=1", bus.rd_valid, bus.rd_data, bus.wr_ack);
    end
    model_mem[3] = 16'h0A0A;
    last_rd = 16'h1003;
    read_one("collision_after", 4'd3, 16'h0A0A);
  endtask

  // Reload with a write and a read on the same edge; then poke requests
  // throughout the load and confirm they are ignored.
  task automatic test_reload_vs_write();
    reload = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h7777;
    bus.rd_en = 1'b1; bus.rd_addr = 4'd5;
    step();
    idle_inputs();
    checks++;
    if (bus.wr_ack !== 1'b0 || bus.rd_valid !== 1'b0 || ready !== 1'b0 || load_idx !== 4'd0 || bus.rd_data !== last_rd) begin
      errors++;
      $display("FAIL reload_edge ack=%b valid=%b ready=%b idx=%0d data=%h want 0 0 0 0 %h", bus.wr_ack, bus.rd_valid, ready, load_idx, bus.rd_data, last_rd);
    end
    for (int k = 1; k < 16; k++) begin
      bus.rd_en = 1'($urandom_range(0, 1)); bus.rd_addr = 4'($urandom_range(0, 15));
      bus.wr_en = 1'($urandom_range(0, 1)); bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 16'($urandom);
      step();
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.wr_ack !== 1'b0 || ready !== 1'b0 || bus.rd_data !== last_rd) begin
        errors++;
        $display("FAIL load_ignore k=%0d valid=%b ack=%b ready=%b data=%h want 0 0 0 %h", k, bus.rd_valid, bus.wr_ack, ready, bus.rd_data, last_rd);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reload_ready got %b want 1", ready);
    end
    model_load();
    read_one("reload_rd7", 4'd7, 16'h1007);
    read_one("reload_rd5", 4'd5, 16'h1005);
    read_all("reload");
  endtask

  // New random presets; a second reload mid-copy restarts from index 0.
  task automatic test_reload_in_load();
    for (int i = 0; i < 16; i++) b[i] = 16'($urandom);
    reload = 1'b1;
    step();
    reload = 1'b0;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (load_idx !== 4'd6) begin
      errors++; $display("FAIL restart_pre idx got %0d want 6", load_idx);
    end
    reload = 1'b1;
    step();
    reload = 1'b0;
    wait_load("restart");
    read_all("restart");
  endtask

  task automatic test_random();
    logic rd_prev, wr_prev;
    rd_prev = 1'b0; wr_prev = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bus.rd_en = 1'($urandom_range(0, 1)); bus.rd_addr = 4'($urandom_range(0, 15));
      bus.wr_en = 1'($urandom_range(0, 1)); bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 16'($urandom);
      if (bus.rd_en) exp_q.push_back(model_mem[bus.rd_addr]);
      if (bus.wr_en) model_mem[bus.wr_addr] = bus.wr_data;
      rd_prev = bus.rd_en; wr_prev = bus.wr_en;
      step();
      checks++;
      if (bus.rd_valid !== rd_prev || bus.wr_ack !== wr_prev) begin
        errors++;
        $display("FAIL rand_hs n=%0d valid=%b ack=%b want %b %b", n, bus.rd_valid, bus.wr_ack, rd_prev, wr_prev);
      end
      if (rd_prev && exp_q.size() > 0) begin
        last_rd = exp_q.pop_front();
        checks++;
        if (bus.rd_data !== last_rd) begin
          errors++; $display("FAIL rand_data n=%0d got %h want %h", n, bus.rd_data, last_rd);
        end
      end
    end
    idle_inputs();
    step();
    read_all("random_final");
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 16; i++) b[i] = 16'h1000 + 16'(i);
    reload = 1'b1;
    step();
    reload = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (load_idx !== 4'd8) begin
      errors++; $display("FAIL midload_idx got %0d want 8", load_idx);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== 16'h0 || bus.rd_valid !== 1'b0 || bus.wr_ack !== 1'b0 || ready !== 1'b0 || load_idx !== 4'd0) begin
      errors++;
      $display("FAIL midload_reset rd_data=%h valid=%b ack=%b ready=%b idx=%0d want all 0", bus.rd_data, bus.rd_valid, bus.wr_ack, ready, load_idx);
    end
    last_rd = 16'h0;
    step();
    Reset_n = 1'b1;
    wait_load("midload");
    read_all("midload");
  endtask

  initial begin
    test_reset();
    test_write();
    test_collision();
    test_reload_vs_write();
    test_reload_in_load();
    test_random();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
